// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V front end.
// Holds the fetch FSM state encoding, reset/bubble values and PC-source codes.
package riscv_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [1:0] PCSRC_SEQ    = 2'b00;
   localparam logic [1:0] PCSRC_TARGET = 2'b01;
   localparam logic [1:0] PCSRC_ALU    = 2'b10;
   localparam logic [1:0] PCSRC_ALT    = 2'b11;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush to bubble, load a new entry, or hold.
// Flush wins over load so a squashed slot can never carry a real instruction.
module if_id_reg
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        load,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_plus4_i,
   input  logic        valid_i,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;

   always_comb begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (flush) begin
         instr_d    = NOP_INSTR;
         pc_d       = 32'h0;
         pc_plus4_d = 32'h0;
         valid_d    = 1'b0;
      end else if (load) begin
         instr_d    = instr_i;
         pc_d       = pc_i;
         pc_plus4_d = pc_plus4_i;
         valid_d    = valid_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q    <= NOP_INSTR;
         pc_q       <= 32'h0;
         pc_plus4_q <= 32'h0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign InstrD   = instr_q;
   assign PCD      = pc_q;
   assign PCPlus4D = pc_plus4_q;
   assign ValidD   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, instruction-memory handshake, redirect and stall handling.
//   state | meaning
//   FETCH | request outstanding at PC
//   HOLD  | fetched word parked in buf while decode is stalled, no request
//   DROP  | redirect arrived mid-request; finish old request, discard data
module fetch_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic [1:0]  PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic [31:0] ALUResultE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pend_q, pend_d;
   logic [31:0]  buf_instr_q, buf_instr_d;
   logic [31:0]  buf_pc_q, buf_pc_d;

   logic        stall, redirect;
   logic [31:0] target;
   logic        ifid_load;
   logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
   logic        ifid_valid;

   assign stall    = StallF | StallD;
   assign redirect = (PCSrcE != PCSRC_SEQ);
   assign target   = word_align((PCSrcE == PCSRC_ALU) ? ALUResultE : PCTargetE);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      ifid_load   = !stall;
      ifid_instr  = NOP_INSTR;
      ifid_pc     = 32'h0;
      ifid_pc4    = 32'h0;
      ifid_valid  = 1'b0;

      case (state_q)
         FETCH: begin
            if (redirect) begin
               if (imem_ready) begin
                  pc_d = target;
               end else begin
                  pend_d  = target;
                  state_d = DROP;
               end
            end else if (imem_ready) begin
               pc_d = pc_q + 32'd4;
               if (!stall) begin
                  ifid_instr = imem_rdata;
                  ifid_pc    = pc_q;
                  ifid_pc4   = pc_q + 32'd4;
                  ifid_valid = 1'b1;
               end else begin
                  buf_instr_d = imem_rdata;
                  buf_pc_d    = pc_q;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = FETCH;
            end else if (!stall) begin
               ifid_instr = buf_instr_q;
               ifid_pc    = buf_pc_q;
               ifid_pc4   = buf_pc_q + 32'd4;
               ifid_valid = 1'b1;
               state_d    = FETCH;
            end
         end
         DROP: begin
            if (redirect) begin
               pend_d = target;
            end
            if (imem_ready) begin
               pc_d    = redirect ? target : pend_q;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         pend_q      <= 32'h0;
         buf_instr_q <= 32'h0;
         buf_pc_q    <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

   // PC only moves on handshake or from HOLD, so addr stays put while a request waits
   assign imem_req  = !rst && (state_q != HOLD);
   assign imem_addr = pc_q;

   if_id_reg u_if_id (
      .clk        (clk),
      .rst        (rst),
      .flush      (FlushD),
      .load       (ifid_load),
      .instr_i    (ifid_instr),
      .pc_i       (ifid_pc),
      .pc_plus4_i (ifid_pc4),
      .valid_i    (ifid_valid),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one-row-per-cycle vector table plus corner sequences.
module tb_fetch_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallF, StallD, FlushD;
   logic [1:0]  PCSrcE;
   logic [31:0] PCTargetE, ALUResultE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        stallf, stalld, flushd;
      logic [1:0]  pcsrc;
      logic [31:0] tgt, alu;
      logic        ready;
      logic        exp_req;
      logic        chk_addr;
      logic [31:0] exp_addr;
      logic        chk_ifid;
      logic [31:0] exp_instr;
      logic        exp_valid;
      logic        chk_pc;
      logic [31:0] exp_pcd, exp_pc4;
   } vec_t;

   fetch_stage dut (
      .clk        (clk),
      .rst        (rst),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .ALUResultE (ALUResultE),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   function automatic vec_t fetch_row(input logic [31:0] a);
      vec_t v;
      v.stallf = 1'b0; v.stalld = 1'b0; v.flushd = 1'b0;
      v.pcsrc = 2'b00; v.tgt = 32'h0; v.alu = 32'h0;
      v.ready = 1'b1;
      v.exp_req = 1'b1; v.chk_addr = 1'b1; v.exp_addr = a;
      v.chk_ifid = 1'b1; v.exp_instr = mem_word(a); v.exp_valid = 1'b1;
      v.chk_pc = 1'b1; v.exp_pcd = a; v.exp_pc4 = a + 32'd4;
      return v;
   endfunction

   function automatic vec_t bubble_row(input logic [31:0] a);
      vec_t v;
      v = fetch_row(a);
      v.ready = 1'b0;
      v.exp_instr = NOP_INSTR;
      v.exp_valid = 1'b0;
      v.chk_pc = 1'b0;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts and ends at a falling edge; address checked before the rising edge, IF/ID after.
   task automatic apply(input vec_t v, input string tag);
      StallF = v.stallf; StallD = v.stalld; FlushD = v.flushd;
      PCSrcE = v.pcsrc; PCTargetE = v.tgt; ALUResultE = v.alu;
      imem_ready = v.ready;
      #1;
      check($sformatf("%s req", tag), {31'b0, imem_req}, {31'b0, v.exp_req});
      if (v.chk_addr) check($sformatf("%s addr", tag), imem_addr, v.exp_addr);
      @(posedge clk);
      #1;
      if (v.chk_ifid) begin
         check($sformatf("%s valid", tag), {31'b0, ValidD}, {31'b0, v.exp_valid});
         check($sformatf("%s instr", tag), InstrD, v.exp_instr);
         if (v.chk_pc) begin
            check($sformatf("%s pcd", tag), PCD, v.exp_pcd);
            check($sformatf("%s pc4", tag), PCPlus4D, v.exp_pc4);
         end
      end
      @(negedge clk);
   endtask

   task automatic reset_and_check(input string tag);
      rst = 1'b1;
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
      PCSrcE = 2'b00; PCTargetE = 32'h0; ALUResultE = 32'h0; imem_ready = 1'b0;
      #1;
      check($sformatf("%s instr", tag), InstrD, NOP_INSTR);
      check($sformatf("%s pcd", tag), PCD, 32'h0);
      check($sformatf("%s pc4", tag), PCPlus4D, 32'h0);
      check($sformatf("%s valid", tag), {31'b0, ValidD}, 32'h0);
      check($sformatf("%s req", tag), {31'b0, imem_req}, 32'h0);
      @(negedge clk);
      check($sformatf("%s req_held", tag), {31'b0, imem_req}, 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v;

      reset_and_check("por");

      for (int a = 0; a <= 'hC; a += 4) tbl.push_back(fetch_row(a));
      for (int i = 0; i < 3; i++) tbl.push_back(bubble_row(32'h10));
      tbl.push_back(fetch_row(32'h10));
      for (int a = 'h14; a <= 'h3C; a += 4) tbl.push_back(fetch_row(a));

      v = fetch_row(32'h40);
      v.stallf = 1'b1; v.stalld = 1'b1;
      v.exp_instr = mem_word(32'h3C); v.exp_pcd = 32'h3C; v.exp_pc4 = 32'h40;
      tbl.push_back(v);
      v.exp_req = 1'b0; v.chk_addr = 1'b0;
      tbl.push_back(v);
      v.stallf = 1'b0; v.stalld = 1'b0;
      v.exp_instr = mem_word(32'h40); v.exp_pcd = 32'h40; v.exp_pc4 = 32'h44;
      tbl.push_back(v);
      tbl.push_back(fetch_row(32'h44));

      v = fetch_row(32'h48);
      v.flushd = 1'b1; v.pcsrc = 2'b10; v.alu = 32'h103;
      v.exp_instr = NOP_INSTR; v.exp_valid = 1'b0; v.chk_pc = 1'b0;
      tbl.push_back(v);
      tbl.push_back(fetch_row(32'h100));

      v = fetch_row(32'h104);
      v.pcsrc = 2'b11; v.tgt = 32'h302; v.chk_ifid = 1'b0;
      tbl.push_back(v);
      tbl.push_back(fetch_row(32'h300));

      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

      // Redirect while a request is waiting
      reset_and_check("rst2");
      for (int a = 0; a <= 'h1C; a += 4) apply(fetch_row(a), "pre_drop");
      v = bubble_row(32'h20);
      v.pcsrc = 2'b01; v.tgt = 32'h200;
      apply(v, "drop_enter");
      apply(bubble_row(32'h20), "drop_wait");
      v = fetch_row(32'h20);
      v.exp_instr = NOP_INSTR; v.exp_valid = 1'b0; v.chk_pc = 1'b0;
      apply(v, "drop_done");
      apply(fetch_row(32'h200), "after_drop");

      // Reset while in DROP
      v = bubble_row(32'h204);
      v.pcsrc = 2'b01; v.tgt = 32'h400;
      apply(v, "drop_again");
      reset_and_check("rst_drop");
      apply(fetch_row(32'h0), "post_rst0");
      apply(fetch_row(32'h4), "post_rst4");

      // PC wraparound, with low target bits forced clear
      v = fetch_row(32'h8);
      v.pcsrc = 2'b01; v.tgt = 32'hFFFF_FFFF; v.chk_ifid = 1'b0;
      apply(v, "wrap_redir");
      apply(fetch_row(32'hFFFF_FFFC), "wrap_top");
      apply(fetch_row(32'h0), "wrap_zero");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: StallF, StallD, FlushD  in  1 each  hazard-unit controls; stall = StallF | StallD.
REQ-004 SHALL have: PCSrcE  in  2  redirect select: 00 sequential, 01 PCTargetE, 10 ALUResultE (jalr), 11 treated as 01.
REQ-005 SHALL have: PCTargetE, ALUResultE  in  32 each  redirect targets from execute.
REQ-006 SHALL have: imem_req  out  1; imem_addr  out  32; imem_ready  in  1; imem_rdata  in  32; rdata valid in the cycle imem_ready=1.
REQ-007 SHALL have: InstrD, PCD, PCPlus4D  out  32 each; ValidD  out  1; registered IF/ID outputs.

Function
REQ-008 SHALL implement FSM states FETCH, HOLD, DROP; redirect = (PCSrcE != 00); target per REQ-004.
REQ-009 Once imem_req is asserted, imem_req and imem_addr SHALL stay stable until imem_ready=1.
REQ-010 FETCH: imem_req=1, imem_addr=PC.
REQ-011 FETCH, redirect, imem_ready=1: PC <= target, rdata discarded, stay FETCH.
REQ-012 FETCH, redirect, imem_ready=0: pend <= target, go DROP.
REQ-013 FETCH, no redirect, imem_ready=1, stall=0: IF/ID <= {rdata, PC, PC+4, valid=1}; PC <= PC+4.
REQ-014 FETCH, no redirect, imem_ready=1, stall=1: buf <= {rdata, PC}; PC <= PC+4; go HOLD.
REQ-015 FETCH, imem_ready=0, stall=0: IF/ID loads bubble (InstrD=0x00000013, ValidD=0).
REQ-016 HOLD: imem_req=0; redirect -> PC <= target, buf discarded, go FETCH; else stall=0 -> IF/ID <= buf (ValidD=1), go FETCH; else stay.
REQ-017 DROP: imem_req=1 at old PC; redirect overwrites pend; imem_ready=1 -> rdata discarded, PC <= pend (or new target if redirect that cycle), go FETCH.
REQ-018 DROP with stall=0: IF/ID loads bubble each cycle.
REQ-019 FlushD=1 SHALL load bubble into IF/ID regardless of StallD or state.
REQ-020 stall=1 and FlushD=0 SHALL hold IF/ID unchanged.
REQ-021 PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000); bits [1:0] of targets SHALL be forced to 00.
REQ-022 Redirect SHALL take priority over every fetch completion and stall in the same cycle.

Reset
REQ-023 rst=1 SHALL immediately set PC=0x00000000, state=FETCH, pend=0, buf=0.
REQ-024 rst=1 SHALL immediately set InstrD=0x00000013, PCD=0, PCPlus4D=0, ValidD=0; imem_req SHALL be 0 while rst=1.
REQ-025 Reset mid-transaction SHALL abandon any outstanding request; first fetch after release SHALL be address 0.

Structure
REQ-026 Shared package riscv_pkg SHALL hold: fetch state enum, RESET_PC=0, NOP_INSTR=0x00000013, PCSrc encodings.
REQ-027 IF/ID register (load, flush, hold) SHALL be sub-module if_id_reg; FSM, PC, pend, buf in fetch_stage.

Verification
REQ-028 Reset, imem_ready tied 1, no stalls -> imem_addr 0,4,8,...; InstrD follows rdata one cycle later, ValidD=1.
REQ-029 imem_ready low 3 cycles at addr 0x10 -> addr held 0x10, three bubbles (ValidD=0), then instr at PCD=0x10.
REQ-030 Redirect PCSrcE=01, PCTargetE=0x200 while addr 0x20 waiting -> DROP; addr stays 0x20 until ready; next imem_addr=0x200; 0x20 data never reaches IF/ID.
REQ-031 StallF=StallD=1 when fetch at 0x40 completes -> HOLD, imem_req=0, IF/ID unchanged; stall release -> PCD=0x40, next addr 0x44.
REQ-032 FlushD=1 with PCSrcE=10, ALUResultE=0x103 -> IF/ID bubble, next imem_addr=0x100.
REQ-033 rst asserted in DROP -> outputs at reset values in same cycle; after release imem_addr=0.
